// File: rtl/blake2_stream.sv
`default_nettype none
// ============================================================================
// Module : blake2_stream
// Multi-block BLAKE2b/BLAKE2s compression engine, one full round per clock.
// Rev    : 1.0
// ============================================================================
module blake2_stream #(
  parameter int W  = 64,
  parameter int R  = 12,
  parameter int R1 = 32,
  parameter int R2 = 24,
  parameter int R3 = 16,
  parameter int R4 = 63
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            blk_valid_i,
  output logic            blk_ready_o,
  input  logic [16*W-1:0] blk_i,
  input  logic [7:0]      blk_len_i,
  input  logic            first_i,
  input  logic            last_i,
  input  logic [7:0]      kk_i,
  input  logic [7:0]      nn_i,
  output logic            hash_valid_o,
  output logic [8*W-1:0]  h_o,
  output logic            err_o
);
  localparam int BB = 2*W;

  // BLAKE2s IV is the upper half of each BLAKE2b IV word
  localparam logic [63:0] c_iv [8] = '{
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};

  localparam logic [3:0] c_sigma [10][16] = '{
    '{ 0, 1, 2, 3, 4, 5, 6, 7, 8, 9,10,11,12,13,14,15},
    '{14,10, 4, 8, 9,15,13, 6, 1,12, 0, 2,11, 7, 5, 3},
    '{11, 8,12, 0, 5, 2,15,13,10,14, 3, 6, 7, 1, 9, 4},
    '{ 7, 9, 3, 1,13,12,11,14, 2, 6, 5,10, 4, 0,15, 8},
    '{ 9, 0, 5, 7, 2, 4,10,15,14, 1,11,12, 6, 8, 3,13},
    '{ 2,12, 6,10, 0,11, 8, 3, 4,13, 7, 5,15,14, 1, 9},
    '{12, 5, 1,15,14,13, 4,10, 0, 7, 6, 3, 9, 2, 8,11},
    '{13,11, 7,14,12, 1, 3, 9, 5, 0,15, 4, 8, 6, 2,10},
    '{ 6,15,14, 9,11, 3, 0, 8,12, 2,13, 7, 1, 4,10, 5},
    '{10, 2, 8, 4, 7, 6, 1, 5,15,11, 9,14, 3,12,13, 0}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FINAL = 2'd2} state_t;

  state_t         r_state;
  logic           r_nreset_q;
  logic [3:0]     r_rc;
  logic [W-1:0]   r_v [16];
  logic [W-1:0]   r_m [16];
  logic [W-1:0]   r_h [8];
  logic [2*W-1:0] r_t;
  logic           r_last;
  logic           r_open;
  logic           r_err;
  logic           r_hash_valid;

  logic           w_acc;
  logic           w_err_hit;
  logic [3:0]     w_srow;
  logic [2*W-1:0] w_t_next;
  logic [W-1:0]   w_hbase [8];
  logic [W-1:0]   w_vinit [16];
  logic [W-1:0]   w_rnd   [16];

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input int n);
    return (x >> n) | (x << (W - n));
  endfunction

  function automatic logic [4*W-1:0] g(input logic [W-1:0] a_in, input logic [W-1:0] b_in,
                                       input logic [W-1:0] c_in, input logic [W-1:0] d_in,
                                       input logic [W-1:0] x,    input logic [W-1:0] y);
    logic [W-1:0] a, b, c, d;
    a = a_in + b_in + x;
    d = rotr(d_in ^ a, R1);
    c = c_in + d;
    b = rotr(b_in ^ c, R2);
    a = a + b + y;
    d = rotr(d ^ a, R3);
    c = c + d;
    b = rotr(b ^ c, R4);
    return {a, b, c, d};
  endfunction

  assign blk_ready_o  = (r_state == S_IDLE) & r_nreset_q;
  assign w_acc        = blk_valid_i & blk_ready_o;
  assign hash_valid_o = r_hash_valid;
  assign err_o        = r_err;
  assign w_err_hit    = (!last_i && blk_len_i != 8'(BB)) || (blk_len_i > 8'(BB)) ||
                        (!first_i && !r_open);
  assign w_t_next     = first_i ? {{(2*W-8){1'b0}}, blk_len_i}
                                : r_t + {{(2*W-8){1'b0}}, blk_len_i};
  assign w_srow       = (r_rc >= 4'd10) ? r_rc - 4'd10 : r_rc;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_hbase[i] = first_i ? c_iv[i][63 -: W] : r_h[i];
    end
    if (first_i) begin
      w_hbase[0] = w_hbase[0] ^ W'(32'h01010000) ^ (W'(kk_i) << 8) ^ W'(nn_i);
    end
    for (int i = 0; i < 8; i++) begin
      w_vinit[i]   = w_hbase[i];
      w_vinit[i+8] = c_iv[i][63 -: W];
    end
    w_vinit[12] = w_vinit[12] ^ w_t_next[W-1:0];
    w_vinit[13] = w_vinit[13] ^ w_t_next[2*W-1:W];
    if (last_i) begin
      w_vinit[14] = ~w_vinit[14];
    end
  end

  // Column step then diagonal step, message words picked by the current SIGMA row
  always_comb begin
    logic [W-1:0] v [16];
    for (int i = 0; i < 16; i++) begin
      v[i] = r_v[i];
    end
    for (int i = 0; i < 4; i++) begin
      {v[i], v[i+4], v[i+8], v[i+12]} = g(v[i], v[i+4], v[i+8], v[i+12],
        r_m[c_sigma[w_srow][2*i]], r_m[c_sigma[w_srow][2*i+1]]);
    end
    for (int i = 0; i < 4; i++) begin
      {v[i], v[4+(i+1)%4], v[8+(i+2)%4], v[12+(i+3)%4]} =
        g(v[i], v[4+(i+1)%4], v[8+(i+2)%4], v[12+(i+3)%4],
          r_m[c_sigma[w_srow][8+2*i]], r_m[c_sigma[w_srow][9+2*i]]);
    end
    for (int i = 0; i < 16; i++) begin
      w_rnd[i] = v[i];
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      h_o[W*i +: W] = r_h[i];
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) begin
      for (int i = 0; i < 16; i++) begin
        r_v[i] <= w_vinit[i];
        r_m[i] <= blk_i[W*i +: W];
      end
    end else if (r_state == S_RUN) begin
      for (int i = 0; i < 16; i++) begin
        r_v[i] <= w_rnd[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_state      <= S_IDLE;
      r_nreset_q   <= 1'b0;
      r_rc         <= 4'd0;
      r_t          <= '0;
      r_last       <= 1'b0;
      r_open       <= 1'b0;
      r_err        <= 1'b0;
      r_hash_valid <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_h[i] <= '0;
      end
    end else begin
      r_nreset_q   <= 1'b1;
      r_hash_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_state <= S_RUN;
            r_rc    <= 4'd0;
            r_t     <= w_t_next;
            r_last  <= last_i;
            r_open  <= ~last_i;
            r_err   <= r_err | w_err_hit;
            for (int i = 0; i < 8; i++) begin
              r_h[i] <= w_hbase[i];
            end
          end
        end
        S_RUN: begin
          r_rc <= r_rc + 4'd1;
          if (r_rc == 4'(R-1)) begin
            r_state <= S_FINAL;
          end
        end
        S_FINAL: begin
          for (int i = 0; i < 8; i++) begin
            r_h[i] <= r_h[i] ^ r_v[i] ^ r_v[i+8];
          end
          r_hash_valid <= r_last;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_blake2_stream.sv
`default_nettype none
// ============================================================================
// Module : tb_blake2_stream
// Directed bench for blake2_stream with an RFC-level BLAKE2 reference model.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_blake2_stream;
  localparam int R = 12;
  localparam int RS = 10;

  localparam logic [63:0] IV [8] = '{
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
  localparam int SIG [10][16] = '{
    '{ 0, 1, 2, 3, 4, 5, 6, 7, 8, 9,10,11,12,13,14,15},
    '{14,10, 4, 8, 9,15,13, 6, 1,12, 0, 2,11, 7, 5, 3},
    '{11, 8,12, 0, 5, 2,15,13,10,14, 3, 6, 7, 1, 9, 4},
    '{ 7, 9, 3, 1,13,12,11,14, 2, 6, 5,10, 4, 0,15, 8},
    '{ 9, 0, 5, 7, 2, 4,10,15,14, 1,11,12, 6, 8, 3,13},
    '{ 2,12, 6,10, 0,11, 8, 3, 4,13, 7, 5,15,14, 1, 9},
    '{12, 5, 1,15,14,13, 4,10, 0, 7, 6, 3, 9, 2, 8,11},
    '{13,11, 7,14,12, 1, 3, 9, 5, 0,15, 4, 8, 6, 2,10},
    '{ 6,15,14, 9,11, 3, 0, 8,12, 2,13, 7, 1, 4,10, 5},
    '{10, 2, 8, 4, 7, 6, 1, 5,15,11, 9,14, 3,12,13, 0}};
  localparam int GI [8][4] = '{
    '{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
    '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  logic          blk_valid_i = 1'b0;
  logic          blk_ready_o;
  logic [1023:0] blk_i = '0;
  logic [7:0]    blk_len_i = '0;
  logic          first_i = 1'b0, last_i = 1'b0;
  logic [7:0]    kk_i = '0, nn_i = 8'd64;
  logic          hash_valid_o;
  logic [511:0]  h_o;
  logic          err_o;

  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [511:0]  s_blk = '0;
  logic [7:0]    s_len = '0;
  logic          s_hv;
  logic [255:0]  s_h;
  logic          s_err;

  blake2_stream #(.W(64), .R(R), .R1(32), .R2(24), .R3(16), .R4(63)) dut (
    .clk(clk), .nreset(nreset), .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o),
    .blk_i(blk_i), .blk_len_i(blk_len_i), .first_i(first_i), .last_i(last_i),
    .kk_i(kk_i), .nn_i(nn_i), .hash_valid_o(hash_valid_o), .h_o(h_o), .err_o(err_o));

  blake2_stream #(.W(32), .R(RS), .R1(16), .R2(12), .R3(8), .R4(7)) dut_s (
    .clk(clk), .nreset(nreset), .blk_valid_i(s_valid), .blk_ready_o(s_ready),
    .blk_i(s_blk), .blk_len_i(s_len), .first_i(1'b1), .last_i(1'b1),
    .kk_i(8'd0), .nn_i(8'd32), .hash_valid_o(s_hv), .h_o(s_h), .err_o(s_err));

  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
    logic [63:0] mask;
    mask = (w == 64) ? 64'hFFFFFFFFFFFFFFFF : 64'h00000000FFFFFFFF;
    return ((x >> n) | (x << (w - n))) & mask;
  endfunction

  function automatic logic [511:0] hinit(input int w, input logic [7:0] kk, input logic [7:0] nn);
    logic [511:0] h;
    for (int i = 0; i < 8; i++) h[64*i +: 64] = IV[i] >> (64 - w);
    h[63:0] = h[63:0] ^ 64'h01010000 ^ ({56'h0, kk} << 8) ^ {56'h0, nn};
    return h;
  endfunction

  // RFC 7693 compression F; words live in 64-bit slots, masked to w bits
  task automatic compress(input int w, input logic [511:0] hin, input logic [1023:0] blk,
                          input logic [127:0] t, input bit last, output logic [511:0] hout);
    logic [63:0] v [16];
    logic [63:0] m [16];
    logic [63:0] mask;
    int nr, r1, r2, r3, r4, a, b, c, d;
    mask = (w == 64) ? 64'hFFFFFFFFFFFFFFFF : 64'h00000000FFFFFFFF;
    if (w == 64) begin nr = 12; r1 = 32; r2 = 24; r3 = 16; r4 = 63; end
    else         begin nr = 10; r1 = 16; r2 = 12; r3 = 8;  r4 = 7;  end
    for (int i = 0; i < 8; i++) begin
      v[i]   = hin[64*i +: 64];
      v[i+8] = IV[i] >> (64 - w);
    end
    v[12] = v[12] ^ (t[63:0] & mask);
    v[13] = v[13] ^ ((w == 64) ? t[127:64] : {32'h0, t[63:32]});
    if (last) v[14] = ~v[14] & mask;
    for (int i = 0; i < 16; i++) m[i] = (w == 64) ? blk[64*i +: 64] : {32'h0, blk[32*i +: 32]};
    for (int rr = 0; rr < nr; rr++) begin
      for (int gi = 0; gi < 8; gi++) begin
        a = GI[gi][0]; b = GI[gi][1]; c = GI[gi][2]; d = GI[gi][3];
        v[a] = (v[a] + v[b] + m[SIG[rr % 10][2*gi]]) & mask;
        v[d] = rotr(v[d] ^ v[a], r1, w);
        v[c] = (v[c] + v[d]) & mask;
        v[b] = rotr(v[b] ^ v[c], r2, w);
        v[a] = (v[a] + v[b] + m[SIG[rr % 10][2*gi+1]]) & mask;
        v[d] = rotr(v[d] ^ v[a], r3, w);
        v[c] = (v[c] + v[d]) & mask;
        v[b] = rotr(v[b] ^ v[c], r4, w);
      end
    end
    for (int i = 0; i < 8; i++) hout[64*i +: 64] = hin[64*i +: 64] ^ v[i] ^ v[i+8];
  endtask

  // Transaction-level model of the W=64 instance
  logic [511:0] mdl_h = '0, mdl_pend = '0;
  logic [127:0] mdl_t = '0;
  bit mdl_open = 0, mdl_err = 0, mdl_nq = 0, mdl_hv = 0, mdl_plast = 0;
  int mdl_busy = 0, mdl_cyc = 0, mdl_nacc = 0, mdl_acc_cyc = 0;

  initial forever begin
    logic [511:0] hb;
    bit rdy;
    @(posedge clk);
    mdl_cyc++;
    if (!nreset) begin
      mdl_h = '0; mdl_t = '0; mdl_open = 0; mdl_err = 0; mdl_nq = 0; mdl_hv = 0; mdl_busy = 0;
    end else begin
      rdy = mdl_nq && (mdl_busy == 0);
      mdl_nq = 1;
      mdl_hv = 0;
      if (mdl_busy > 0) begin
        mdl_busy--;
        if (mdl_busy == 0) begin
          mdl_h  = mdl_pend;
          mdl_hv = mdl_plast;
        end
      end else if (rdy && blk_valid_i) begin
        if (blk_len_i > 128 || (!last_i && blk_len_i != 128) || (!first_i && !mdl_open)) mdl_err = 1;
        if (first_i) begin
          hb = hinit(64, kk_i, nn_i);
          mdl_t = {120'h0, blk_len_i};
        end else begin
          hb = mdl_h;
          mdl_t = mdl_t + {120'h0, blk_len_i};
        end
        mdl_open = !last_i;
        mdl_h = hb;
        compress(64, hb, blk_i, mdl_t, last_i, mdl_pend);
        mdl_plast = last_i;
        mdl_busy = R + 1;
        mdl_nacc++;
        mdl_acc_cyc = mdl_cyc;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    check("ready", {511'h0, blk_ready_o}, {511'h0, (mdl_nq && mdl_busy == 0)});
    check("hash_valid", {511'h0, hash_valid_o}, {511'h0, mdl_hv});
    check("err", {511'h0, err_o}, {511'h0, mdl_err});
    check("h_o", h_o, mdl_h);
  end

  function automatic logic [1023:0] fill(input int base, input int len);
    logic [1023:0] b;
    b = '0;
    for (int i = 0; i < len; i++) b[8*i +: 8] = 8'((base + i) & 255);
    return b;
  endfunction

  task automatic send(input logic [1023:0] b, input int len, input bit f, input bit l,
                      input int kk, input bit keep);
    int n0;
    bit got;
    n0 = mdl_nacc;
    got = 0;
    blk_i = b; blk_len_i = 8'(len); first_i = f; last_i = l; kk_i = 8'(kk); nn_i = 8'd64;
    blk_valid_i = 1'b1;
    for (int k = 0; k < 100 && !got; k++) begin
      @(posedge clk); #1;
      if (mdl_nacc != n0) got = 1;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL accept_timeout: got no accept expected accept within 100 cycles");
    end
    blk_valid_i = keep;
  endtask

  task automatic wait_digest(output logic [511:0] d, output int lat);
    bit got;
    got = 0; d = '0; lat = -1;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (hash_valid_o) begin
        got = 1; d = h_o; lat = mdl_cyc + 1 - mdl_acc_cyc;
      end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL digest_timeout: got no hash_valid_o expected pulse within 60 cycles");
    end
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [511:0] d, ms;
    logic [255:0] sexp;
    int lat, a0, n, hv_seen;
    bit got;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {511'h0, blk_ready_o}, 512'h0);
    check("rst_h", h_o, 512'h0);
    check("rst_err", {511'h0, err_o}, 512'h0);
    #1 nreset = 1'b1;
    @(posedge clk); #1;

    // BLAKE2s "abc"
    s_blk = 512'h636261; s_len = 8'd3; s_valid = 1'b1;
    @(posedge clk); #1 s_valid = 1'b0;
    got = 0; n = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk); n++;
      if (s_hv) got = 1;
    end
    check("s_latency", 512'(n), 512'(RS + 2));
    check("s_h0", {480'h0, s_h[31:0]}, {480'h0, 32'h8C5E8C50});
    check("s_h7", {480'h0, s_h[255:224]}, {480'h0, 32'h82596786});
    compress(32, hinit(32, 8'd0, 8'd32), {512'h0, s_blk}, 128'd3, 1'b1, ms);
    for (int i = 0; i < 8; i++) sexp[32*i +: 32] = ms[64*i +: 32];
    check("s_model", {256'h0, s_h}, {256'h0, sexp});

    // BLAKE2b "abc"
    send(fill(8'h61, 3), 3, 1, 1, 0, 0);
    wait_digest(d, lat);
    check("abc_latency", 512'(lat), 512'(R + 2));
    check("abc_h0", {448'h0, d[63:0]}, {448'h0, 64'h0D4D1C983FA580BA});
    check("abc_h7", {448'h0, d[511:448]}, {448'h0, 64'h239900D4ED8623B9});

    // empty message
    send('0, 0, 1, 1, 0, 0);
    wait_digest(d, lat);
    check("empty_h0", {448'h0, d[63:0]}, {448'h0, 64'h03590142F7026A78});
    check("empty_h7", {448'h0, d[511:448]}, {448'h0, 64'hCEE29BFE1A706FD5});

    // 300-byte message, valid held high across all three blocks
    send(fill(0, 128), 128, 1, 0, 0, 1);
    check("t_blk0", 512'(dut.r_t), 512'd128);
    a0 = mdl_acc_cyc;
    send(fill(128, 128), 128, 0, 0, 0, 1);
    check("t_blk1", 512'(dut.r_t), 512'd256);
    check("gap_blk1", 512'(mdl_acc_cyc - a0), 512'(R + 2));
    a0 = mdl_acc_cyc;
    send(fill(0, 44), 44, 0, 1, 0, 0);
    check("t_blk2", 512'(dut.r_t), 512'd300);
    check("gap_blk2", 512'(mdl_acc_cyc - a0), 512'(R + 2));
    wait_digest(d, lat);
    check("multi_err", {511'h0, err_o}, 512'h0);

    // keyed, valid raised while the engine is still busy
    repeat ($urandom_range(0, 4)) @(posedge clk);
    #1 send(fill(0, 64), 128, 1, 0, 64, 0);
    repeat ($urandom_range(0, 5)) @(posedge clk);
    #1 send(fill(8'h5A, 1), 1, 0, 1, 64, 0);
    wait_digest(d, lat);
    check("keyed_latency", 512'(lat), 512'(R + 2));

    // short non-last block is flagged and the flag sticks
    send(fill(0, 100), 100, 1, 0, 0, 0);
    send(fill(7, 5), 5, 0, 1, 0, 0);
    wait_digest(d, lat);
    check("err_sticky", {511'h0, err_o}, {511'h0, 1'b1});

    // reset during RUN aborts silently
    do_reset();
    send(fill(8'h61, 3), 3, 1, 1, 0, 0);
    repeat (4) @(posedge clk);
    #1 nreset = 1'b0;
    @(posedge clk); #1 nreset = 1'b1;
    hv_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (hash_valid_o) hv_seen++;
    end
    check("abort_no_pulse", 512'(hv_seen), 512'd0);
    check("abort_h", h_o, 512'h0);
    check("abort_err", {511'h0, err_o}, 512'h0);

    // continuation with no open message
    send(fill(8'h61, 3), 3, 0, 1, 0, 0);
    wait_digest(d, lat);
    check("orphan_err", {511'h0, err_o}, {511'h0, 1'b1});

    // new message mid-message restarts cleanly
    do_reset();
    send(fill(0, 128), 128, 1, 0, 0, 0);
    send(fill(8'h61, 3), 3, 1, 1, 0, 0);
    wait_digest(d, lat);
    check("restart_h0", {448'h0, d[63:0]}, {448'h0, 64'h0D4D1C983FA580BA});
    check("restart_h7", {448'h0, d[511:448]}, {448'h0, 64'h239900D4ED8623B9});
    check("restart_err", {511'h0, err_o}, 512'h0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
